// File: rtl/ext_pkg.sv
// ext_pkg: extension mode encodings shared by the extender pipeline.
package ext_pkg;
  typedef logic [1:0] ext_mode_t;
  localparam ext_mode_t EXT_ZERO  = 2'b00;
  localparam ext_mode_t EXT_SIGN  = 2'b01;
  localparam ext_mode_t EXT_UPPER = 2'b10;
  localparam ext_mode_t EXT_SHAMT = 2'b11;
endpackage

// File: rtl/ext_core.sv
// ext_core: combinational zero/sign/upper/shift-amount extender.
module ext_core import ext_pkg::*; #(
  parameter int IN_W    = 16,
  parameter int OUT_W   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [IN_W-1:0]  x,
  input  ext_mode_t        mode,
  output logic [OUT_W-1:0] y
);
  localparam int E = OUT_W - IN_W;
  always_comb
    y = mode == EXT_ZERO  ? {{E{1'b0}}, x} :
        mode == EXT_SIGN  ? {{E{x[IN_W-1]}}, x} :
        mode == EXT_UPPER ? {x, {E{1'b0}}} :
                            {{(OUT_W-SHAMT_W){1'b0}}, x[SHAMT_W-1:0]};
endmodule

// File: rtl/ext_pipe.sv
// ext_pipe: extender behind a valid/ready output register with a one-entry skid buffer.
module ext_pipe import ext_pkg::*; #(
  parameter int IN_W    = 16,
  parameter int OUT_W   = 32,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_x,
  input  ext_mode_t        in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_y,
  output logic [TAG_W-1:0] out_tag
);
  logic [OUT_W-1:0] y, skid_y;
  logic [TAG_W-1:0] skid_tag;
  logic skid_valid, acc, free, skid_valid_n;
  if (IN_W >= OUT_W) begin : g_chk_w
    $error("ext_pipe: IN_W must be smaller than OUT_W");
  end
  if (SHAMT_W > IN_W) begin : g_chk_s
    $error("ext_pipe: SHAMT_W must not exceed IN_W");
  end
  ext_core #(.IN_W(IN_W), .OUT_W(OUT_W), .SHAMT_W(SHAMT_W)) u_core (
    .x(in_x),
    .mode(in_mode),
    .y(y)
  );
  // main is free when empty or draining; skid only ever fills behind a stalled main
  always_comb begin
    acc = in_valid && in_ready;
    free = !out_valid || out_ready;
    skid_valid_n = !free && (skid_valid || acc);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      out_y <= '0;
      out_tag <= '0;
      skid_valid <= 1'b0;
      skid_y <= '0;
      skid_tag <= '0;
    end else begin
      in_ready <= !skid_valid_n;
      skid_valid <= skid_valid_n;
      if (free) begin
        out_valid <= skid_valid || acc;
        out_y <= skid_valid ? skid_y : acc ? y : out_y;
        out_tag <= skid_valid ? skid_tag : acc ? in_tag : out_tag;
      end else if (acc) begin
        skid_y <= y;
        skid_tag <= in_tag;
      end
    end
endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: directed and scoreboarded checks of the ext_pipe handshake and extension modes.
module tb_ext_pipe;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [15:0] in_x = 0;
  logic [1:0] in_mode = 0;
  logic [4:0] in_tag = 0, out_tag;
  logic [31:0] out_y;
  int n_asrt = 0, n_fail = 0, n_out = 0;
  logic [36:0] q[$];

  ext_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_ext(input logic [15:0] x, input logic [1:0] m);
    int s;
    s = $signed(x);
    case (m)
      2'd0: return {16'h0000, x};
      2'd1: return s;
      2'd2: return {x, 16'h0000};
      default: return {27'd0, x[4:0]};
    endcase
  endfunction

  // one clock of handshake traffic with scoreboard and stall-stability checks
  task automatic cycle(input logic iv, input logic ordy);
    logic acc, drn, st;
    logic [36:0] e;
    logic [31:0] py;
    logic [4:0] pt;
    in_valid = iv;
    out_ready = ordy;
    in_x = 16'($urandom);
    in_mode = 2'($urandom);
    in_tag = 5'($urandom);
    acc = in_valid && in_ready;
    drn = out_valid && out_ready;
    if (drn) begin
      n_out++;
      if (q.size() == 0) chk("extra_out", 1, 0);
      else begin
        e = q.pop_front();
        chk("sb_y", out_y, e[31:0]);
        chk("sb_tag", out_tag, e[36:32]);
      end
    end
    if (acc) q.push_back({in_tag, ref_ext(in_x, in_mode)});
    st = out_valid && !out_ready;
    py = out_y;
    pt = out_tag;
    step();
    if (st) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_y", out_y, py);
      chk("stall_tag", out_tag, pt);
    end
  endtask

  initial begin
    logic [31:0] exp_m[4];
    exp_m[0] = 32'h00008001;
    exp_m[1] = 32'hFFFF8001;
    exp_m[2] = 32'h80010000;
    exp_m[3] = 32'h00000001;
    in_valid = 1;
    in_x = 16'h1234;
    repeat (3) step();
    chk("rst_valid", out_valid, 0);
    chk("rst_y", out_y, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_ready", in_ready, 0);
    rst_n = 1;
    in_valid = 0;
    step();
    chk("rel_ready", in_ready, 1);
    chk("rel_valid", out_valid, 0);
    out_ready = 1;
    for (int m = 0; m < 4; m++) begin
      in_valid = 1;
      in_x = 16'h8001;
      in_mode = 2'(m);
      in_tag = 5'(10 + m);
      step();
      chk($sformatf("mode%0d_valid", m), out_valid, 1);
      chk($sformatf("mode%0d_y", m), out_y, exp_m[m]);
      chk($sformatf("mode%0d_tag", m), out_tag, 5'(10 + m));
    end
    in_valid = 0;
    step();
    chk("sweep_idle", out_valid, 0);
    out_ready = 0;
    in_valid = 1;
    in_mode = 2'b00;
    in_x = 16'h0101;
    in_tag = 5'd1;
    step();
    chk("bp1_tag", out_tag, 1);
    chk("bp1_ready", in_ready, 1);
    in_x = 16'h0202;
    in_tag = 5'd2;
    step();
    chk("bp2_tag", out_tag, 1);
    chk("bp2_ready", in_ready, 0);
    in_x = 16'h0303;
    in_tag = 5'd3;
    step();
    chk("bp3_tag", out_tag, 1);
    chk("bp3_ready", in_ready, 0);
    step();
    chk("bp4_y", out_y, 32'h00000101);
    out_ready = 1;
    step();
    chk("bp_out2_tag", out_tag, 2);
    chk("bp_out2_y", out_y, 32'h00000202);
    chk("bp_out2_ready", in_ready, 1);
    step();
    chk("bp_out3_valid", out_valid, 1);
    chk("bp_out3_tag", out_tag, 3);
    chk("bp_out3_y", out_y, 32'h00000303);
    in_valid = 0;
    step();
    chk("bp_idle", out_valid, 0);
    n_out = 0;
    for (int i = 0; i < 100; i++) begin
      cycle(1, 1);
      chk("fr_valid", out_valid, 1);
    end
    cycle(0, 1);
    chk("fr_count", n_out, 100);
    chk("fr_empty", q.size(), 0);
    chk("fr_idle", out_valid, 0);
    for (int i = 0; i < 3000; i++) cycle(1'($urandom), 1'($urandom));
    for (int i = 0; i < 4 && (q.size() != 0 || out_valid); i++) cycle(0, 1);
    chk("rnd_drained", q.size(), 0);
    chk("rnd_idle", out_valid, 0);
    cycle(1, 0);
    cycle(1, 0);
    chk("mid_full_valid", out_valid, 1);
    chk("mid_full_ready", in_ready, 0);
    rst_n = 0;
    in_valid = 1;
    out_ready = 1;
    step();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 0);
    q.delete();
    rst_n = 1;
    in_valid = 0;
    step();
    chk("mid_rel_ready", in_ready, 1);
    chk("mid_rel_valid", out_valid, 0);
    n_out = 0;
    cycle(1, 1);
    cycle(0, 1);
    cycle(0, 1);
    chk("post_rst_count", n_out, 1);
    chk("post_rst_idle", out_valid, 0);
    chk("post_rst_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
